pulse_train_generator: RTL and testbench

Programmable square-wave / burst generator that produces the oscillating test stimulus measured by the on-chip edge-counting frequency counter. It drives `sig_out` with a software-chosen half-period and an optional burst length, so the counter path can be calibrated and verified against a known edge count. It sits beside the counter in the measurement subsystem and is configured from the control register block.

---
 rtl/meas_pkg.sv | 22 ++
 rtl/half_period_timer.sv | 35 +++
 rtl/pulse_train_generator.sv | 140 ++++++++++++++
 tb/tb_pulse_train_generator.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// -----------------------------------------------------------------------------
// meas_pkg
// Definitions shared by the measurement subsystem: the pulse train generator
// and the edge-counting frequency counter it calibrates.
//   DEF_DIV_WIDTH   default width of the generator half-period setting
//   DEF_BURST_WIDTH default width of the burst length / pulse counter
//   COUNT_WIDTH     edge counter width of the companion frequency counter
//   ptg_state_t     generator FSM states (IDLE / HIGH / LOW)
// -----------------------------------------------------------------------------
package meas_pkg;

    localparam int unsigned DEF_DIV_WIDTH   = 16;
    localparam int unsigned DEF_BURST_WIDTH = 16;
    localparam int unsigned COUNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ptg_state_t;

endpackage

// File: rtl/half_period_timer.sv
// -----------------------------------------------------------------------------
// half_period_timer
// Down-counter that times one high or low phase of the generated waveform.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val into the counter (takes priority over dec)
//   load_val    phase length minus one
//   dec         decrement the counter by one
//   expired     counter has reached zero (last cycle of the current phase)
// -----------------------------------------------------------------------------
module half_period_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] ph_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt <= '0;
        end else if (load) begin
            ph_cnt <= load_val;
        end else if (dec) begin
            ph_cnt <= ph_cnt - WIDTH'(1);
        end
    end

    assign expired = (ph_cnt == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// -----------------------------------------------------------------------------
// pulse_train_generator
// Programmable square-wave / burst generator feeding the frequency counter.
//   clk, rst_n       clock, asynchronous active-low reset
//   cfg_valid        configuration offer; accepted when cfg_ready is high
//   cfg_ready        high only while idle
//   cfg_half_period  clk cycles per high/low phase (0 behaves as 1)
//   cfg_burst_len    rising edges per burst (0 = run until stopped)
//   start            start request, honoured only while idle
//   stop             abort request, honoured in any state
//   sig_out          generated waveform (registered)
//   busy             high while the waveform is running
//   done             one-cycle pulse when a burst completes normally
//   pulse_count      rising edges emitted since the last start
// -----------------------------------------------------------------------------
module pulse_train_generator
    import meas_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = DEF_DIV_WIDTH,
    parameter int unsigned BURST_WIDTH = DEF_BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DIV_WIDTH-1:0]   cfg_half_period,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    input  logic                   start,
    input  logic                   stop,
    output logic                   sig_out,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] pulse_count
);

    ptg_state_t             state;
    logic [DIV_WIDTH-1:0]   hp_r;
    logic [BURST_WIDTH-1:0] bl_r;

    logic                   cfg_fire;
    logic [DIV_WIDTH-1:0]   cfg_hp_clamped;
    logic [DIV_WIDTH-1:0]   start_hp;
    logic                   start_go;
    logic                   running;
    logic                   tmr_load;
    logic                   tmr_dec;
    logic [DIV_WIDTH-1:0]   tmr_load_val;
    logic                   tmr_expired;
    logic                   burst_end;

    assign cfg_ready      = (state == ST_IDLE);
    assign cfg_fire       = cfg_valid & cfg_ready;
    assign cfg_hp_clamped = (cfg_half_period == '0) ? DIV_WIDTH'(1) : cfg_half_period;

    // A configuration offered in the same cycle as start applies to that
    // start, so the first phase length bypasses hp_r.
    assign start_hp = cfg_fire ? cfg_hp_clamped : hp_r;

    assign start_go  = (state == ST_IDLE) & start & ~stop;
    assign running   = (state != ST_IDLE) & ~stop;
    assign burst_end = (bl_r != '0) && (pulse_count == bl_r);

    always_comb begin
        tmr_load     = start_go | (running & tmr_expired);
        tmr_dec      = running & ~tmr_expired;
        tmr_load_val = (start_go ? start_hp : hp_r) - DIV_WIDTH'(1);
    end

    half_period_timer #(
        .WIDTH (DIV_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sig_out     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_count <= '0;
            hp_r        <= DIV_WIDTH'(1);
            bl_r        <= '0;
        end else begin
            done <= 1'b0;

            if (cfg_fire) begin
                hp_r <= cfg_hp_clamped;
                bl_r <= cfg_burst_len;
            end

            if (stop) begin
                state   <= ST_IDLE;
                sig_out <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state       <= ST_HIGH;
                            sig_out     <= 1'b1;
                            busy        <= 1'b1;
                            pulse_count <= BURST_WIDTH'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (tmr_expired) begin
                            state   <= ST_LOW;
                            sig_out <= 1'b0;
                        end
                    end
                    ST_LOW: begin
                        if (tmr_expired) begin
                            if (burst_end) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state       <= ST_HIGH;
                                sig_out     <= 1'b1;
                                pulse_count <= pulse_count + BURST_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        sig_out <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
module tb_pulse_train_generator;

    localparam int DW = 16;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [DW-1:0] cfg_half_period = '0;
    logic [BW-1:0] cfg_burst_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sig_out;
    logic          busy;
    logic          done;
    logic [BW-1:0] pulse_count;

    pulse_train_generator #(
        .DIV_WIDTH   (DW),
        .BURST_WIDTH (BW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_half_period (cfg_half_period),
        .cfg_burst_len   (cfg_burst_len),
        .start           (start),
        .stop            (stop),
        .sig_out         (sig_out),
        .busy            (busy),
        .done            (done),
        .pulse_count     (pulse_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected observable events: 0 = falling edge, 1 = rising edge, 2 = done
    typedef struct {
        int kind;
        int t;
        int cnt;
        bit bsy;
    } ev_t;

    ev_t  q[$];
    bit   mon_en = 1'b0;
    logic prev_sig = 1'b0;
    int   m_kind;
    ev_t  m_e;

    // Reference model configuration state
    int m_hp = 1;
    int m_bl = 0;
    int exp_final = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every edge of sig_out and every done pulse must match the
    // next expected event exactly in time, pulse count and status.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1 || sig_out !== prev_sig) begin
                m_kind = (done === 1'b1) ? 2 : ((sig_out === 1'b1) ? 1 : 0);
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL event: unexpected kind %0d at cycle %0d count %0d", m_kind, cyc, pulse_count);
                end else begin
                    m_e = q.pop_front();
                    if (m_e.kind != m_kind || m_e.t != cyc || m_e.cnt != int'(pulse_count) ||
                        busy !== m_e.bsy || cfg_ready !== !m_e.bsy) begin
                        errors++;
                        $display("FAIL event: got kind %0d cyc %0d cnt %0d busy %b rdy %b, expected kind %0d cyc %0d cnt %0d busy %b rdy %b",
                                 m_kind, cyc, pulse_count, busy, cfg_ready,
                                 m_e.kind, m_e.t, m_e.cnt, m_e.bsy, !m_e.bsy);
                    end
                end
            end
            prev_sig = sig_out;
        end
    end

    // Reference: started in the cycle observed as c, the waveform is high
    // for the first hp cycles of every 2*hp-cycle period, with the period
    // index giving the pulse count. lim (absolute cycle, 0 = none) is the
    // last cycle with normal behaviour before a stop or a reset takes effect.
    task automatic plan(input int c, input int hp, input int n, input int lim,
                        input bit is_stop, output int last_t);
        int per;
        int end_t;
        int tmax;
        bit lvl;
        bit pv;
        int cnt;
        per   = 2 * hp;
        end_t = (n == 0) ? 32'h7fff_ffff : c + n * per;
        tmax  = (lim != 0 && lim < end_t) ? lim : end_t;
        pv    = 1'b0;
        cnt   = 0;
        for (int t = c + 1; t <= tmax; t++) begin
            lvl = ((t - c - 1) % per) < hp;
            cnt = (t - c - 1) / per + 1;
            if (lvl != pv) q.push_back('{lvl ? 1 : 0, t, cnt, 1'b1});
            pv = lvl;
        end
        exp_final = cnt;
        if (lim != 0 && lim <= end_t) begin
            if (is_stop) begin
                last_t = lim + 1;
                if (pv) q.push_back('{0, lim + 1, cnt, 1'b0});
            end else begin
                last_t = lim;
            end
        end else begin
            q.push_back('{2, end_t + 1, n, 1'b0});
            last_t = end_t + 1;
        end
    endtask

    task automatic cfg(input int hp, input int bl);
        @(negedge clk);
        cfg_valid       = 1'b1;
        cfg_half_period = DW'(hp);
        cfg_burst_len   = BW'(bl);
        chk("cfg_ready_idle", int'(cfg_ready), 1);
        m_hp = (hp == 0) ? 1 : hp;
        m_bl = bl;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // One start; s_rel / r_rel = cycles after start at which stop is driven
    // or reset is asserted (0 = none). While busy, ignored start and
    // cfg_valid requests are sprinkled in at random.
    task automatic run(input bit use_cfg, input int hp_in, input int bl_in,
                       input int s_rel, input int r_rel);
        int c;
        int hp;
        int n;
        int lim;
        int last_t;
        int busy_end;
        bit is_stop;
        bit did_reset;
        @(negedge clk);
        start = 1'b1;
        if (use_cfg) begin
            cfg_valid       = 1'b1;
            cfg_half_period = DW'(hp_in);
            cfg_burst_len   = BW'(bl_in);
            m_hp = (hp_in == 0) ? 1 : hp_in;
            m_bl = bl_in;
        end
        c         = cyc;
        hp        = m_hp;
        n         = m_bl;
        is_stop   = (s_rel != 0);
        lim       = is_stop ? c + s_rel : ((r_rel != 0) ? c + r_rel : 0);
        did_reset = 1'b0;
        plan(c, hp, n, lim, is_stop, last_t);
        if (n == 0) busy_end = lim;
        else busy_end = (lim != 0 && lim < c + n * 2 * hp) ? lim : c + n * 2 * hp;

        while (cyc < last_t + 3) begin
            @(negedge clk);
            start     = 1'b0;
            cfg_valid = 1'b0;
            stop      = 1'b0;
            if (cyc == c + 1) chk("cfg_ready_busy", int'(cfg_ready), 0);
            if (cyc <= busy_end) begin
                if ($urandom_range(3) == 0) start = 1'b1;
                if ($urandom_range(3) == 0) begin
                    cfg_valid       = 1'b1;
                    cfg_half_period = DW'($urandom_range(9));
                    cfg_burst_len   = BW'($urandom_range(5));
                end
            end
            if (is_stop && cyc == lim) stop = 1'b1;
            if (!is_stop && r_rel != 0 && cyc == lim) begin
                #2;
                start     = 1'b0;
                cfg_valid = 1'b0;
                rst_n     = 1'b0;
                mon_en    = 1'b0;
                #1;
                chk("events_before_reset", q.size(), 0);
                chk("rst_sig_out", int'(sig_out), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_pulse_count", int'(pulse_count), 0);
                chk("rst_cfg_ready", int'(cfg_ready), 1);
                q.delete();
                repeat (2) @(negedge clk);
                rst_n    = 1'b1;
                m_hp     = 1;
                m_bl     = 0;
                prev_sig = 1'b0;
                mon_en   = 1'b1;
                did_reset = 1'b1;
                break;
            end
        end
        start     = 1'b0;
        cfg_valid = 1'b0;
        stop      = 1'b0;
        if (!did_reset) begin
            chk("events_drained", q.size(), 0);
            chk("final_pulse_count", int'(pulse_count), exp_final);
            chk("final_busy", int'(busy), 0);
            chk("final_sig_out", int'(sig_out), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int hp;
        int bl;
        int hpe;
        int s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_reset_sig_out", int'(sig_out), 0);
        chk("in_reset_cfg_ready", int'(cfg_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_sig_out", int'(sig_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pulse_count", int'(pulse_count), 0);
        chk("reset_cfg_ready", int'(cfg_ready), 1);
        prev_sig = 1'b0;
        mon_en   = 1'b1;

        // hp=3, burst of 4
        cfg(3, 4);
        run(1'b0, 0, 0, 0, 0);
        // hp=0 treated as 1, burst of 2
        cfg(0, 2);
        run(1'b0, 0, 0, 0, 0);
        // continuous hp=2, stopped mid-HIGH of the 5th pulse
        cfg(2, 0);
        run(1'b0, 0, 0, 18, 0);
        // config offered together with start
        cfg(3, 2);
        run(1'b1, 5, 1, 0, 0);
        // stop on the final LOW cycle beats burst completion
        cfg(1, 3);
        run(1'b0, 0, 0, 6, 0);
        // reset in the middle of a LOW phase, then defaults
        cfg(3, 4);
        run(1'b0, 0, 0, 0, 5);
        run(1'b0, 0, 0, 10, 0);

        for (int i = 0; i < 14; i++) begin
            hp  = $urandom_range(3);
            bl  = $urandom_range(3);
            hpe = (hp == 0) ? 1 : hp;
            if (bl == 0) s = $urandom_range(25, 1);
            else if ($urandom_range(1) == 0) s = $urandom_range(bl * 2 * hpe + 1, 1);
            else s = 0;
            if ($urandom_range(1) == 0) begin
                run(1'b1, hp, bl, s, 0);
            end else begin
                cfg(hp, bl);
                run(1'b0, 0, 0, s, 0);
            end
            repeat ($urandom_range(2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
